rx_fifo_arbiter: RTL and testbench
==================================

RX_FIFO_ARBITER -- requirements
Module: rx_fifo_arbiter

Interface
REQ-001 SHALL have parameter BURST, default 4, max bytes popped per grant (legal 1..15).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port empty  input  1  rx_fifo empty flag.
REQ-005 SHALL have port r_data  input  8  rx_fifo head byte, first-word-fall-through.
REQ-006 SHALL have port r_enable  output  1  rx_fifo pop strobe, one byte per asserted cycle.
REQ-007 SHALL have port req0  input  1  requester 0 wants bytes (level).
REQ-008 SHALL have port req1  input  1  requester 1 wants bytes (level).
REQ-009 SHALL have port rdy0  input  1  requester 0 can accept a byte this cycle.
REQ-010 SHALL have port rdy1  input  1  requester 1 can accept a byte this cycle.
REQ-011 SHALL have port gnt0  output  1  requester 0 owns the FIFO read port (registered).
REQ-012 SHALL have port gnt1  output  1  requester 1 owns the FIFO read port (registered).
REQ-013 SHALL have port data_out  output  8  registered popped byte.
REQ-014 SHALL have port valid0  output  1  data_out valid for requester 0, one-cycle pulse.
REQ-015 SHALL have port valid1  output  1  data_out valid for requester 1, one-cycle pulse.

Function
REQ-016 SHALL implement states IDLE, GRANT0, GRANT1; gnt0=1 only in GRANT0, gnt1=1 only in GRANT1; never both.
REQ-017 SHALL in IDLE: req0 only -> GRANT0; req1 only -> GRANT1; neither -> stay IDLE.
REQ-018 SHALL in IDLE with req0 and req1 both high grant the requester not granted last (round-robin); last_gnt updates on every IDLE->GRANTn transition.
REQ-019 SHALL assert r_enable combinationally in GRANTn iff reqn=1, rdyn=1, empty=0, beat count < BURST; never in IDLE.
REQ-020 SHALL on each pop edge load data_out <= r_data and assert validn for exactly the next cycle; latency pop-to-valid = 1 cycle.
REQ-021 SHALL hold data_out unchanged when no pop occurs; validn deasserts the cycle after its pop unless another pop follows.
REQ-022 SHALL keep a 4-bit beat counter, cleared on entry to GRANTn, incremented per pop, never exceeding BURST.
REQ-023 SHALL go GRANTn->IDLE on the edge where the BURST-th pop occurs, or on any edge with reqn=0; no pop when reqn=0.
REQ-024 SHALL stay in GRANTn without popping while empty=1 or rdyn=0 (back-pressure); count held.
REQ-025 SHALL insert exactly one IDLE cycle between consecutive grants (no direct GRANT0->GRANT1).
REQ-026 SHALL ignore req/rdy of the non-granted requester entirely.
REQ-027 SHALL resolve simultaneous BURST-th pop and reqn drop as a normal release: byte delivered (validn pulse), then IDLE.

Reset
REQ-028 SHALL on n_rst=0 immediately force state=IDLE, gnt0=gnt1=0, valid0=valid1=0, data_out=8'h00, beat count=0, last_gnt=1 (so requester 0 wins first tie), r_enable=0.
REQ-029 SHALL on reset mid-burst abandon the burst with no further pops; remaining FIFO contents untouched.

Verification
REQ-030 SHALL cover: reset, FIFO holds 8'hA5,8'h3C, req0=rdy0=1 -> gnt0 next cycle, two r_enable pulses, valid0 with data_out 8'hA5 then 8'h3C, gnt0 held with empty=1.
REQ-031 SHALL cover: FIFO full (8 bytes), BURST=4, req0=req1=rdy0=rdy1=1 from reset -> GRANT0 4 pops, 1 IDLE cycle, GRANT1 4 pops, IDLE, GRANT0 (no pops, empty).
REQ-032 SHALL cover: GRANT1, rdy1 low for 3 cycles mid-burst -> no r_enable in those cycles, beat count held, burst completes after rdy1 returns.
REQ-033 SHALL cover: req0 dropped after 2 of 4 pops -> release next edge, exactly 2 valid0 pulses, 6 bytes remain, empty=0.
REQ-034 SHALL cover: n_rst asserted during GRANT0 after 1 pop -> outputs at reset values within same cycle, no r_enable, after release req1 alone -> GRANT1.
REQ-035 SHALL cover: empty=1 throughout with req0=rdy0=1 for 10 cycles -> r_enable never asserted, valid0 never asserted, gnt0 held.

Source files
------------

// File: rtl/rx_fifo_arbiter.sv
// rx_fifo_arbiter: round-robin burst arbiter draining an rx FIFO to two requesters
module rx_fifo_arbiter #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       empty,
  input  logic [7:0] r_data,
  output logic       r_enable,
  input  logic       req0,
  input  logic       req1,
  input  logic       rdy0,
  input  logic       rdy1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] data_out,
  output logic       valid0,
  output logic       valid1
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam logic [3:0] BURST_L = 4'(BURST);
  state_t state, state_nxt;
  logic last_gnt;
  logic [3:0] cnt;
  logic req_g, rdy_g;
  assign gnt0 = state == GRANT0;
  assign gnt1 = state == GRANT1;
  // only the owner's handshake matters; pop while owner wants, can take, FIFO has data, burst not spent
  always_comb begin
    req_g = gnt0 ? req0 : gnt1 ? req1 : 1'b0;
    rdy_g = gnt0 ? rdy0 : gnt1 ? rdy1 : 1'b0;
    r_enable = req_g & rdy_g & ~empty & (cnt < BURST_L);
  end
  // next owner: round-robin on ties from IDLE, release on req drop or last burst beat
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (req0 & req1) ? (last_gnt ? GRANT0 : GRANT1) :
                  req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
    else if (!req_g || (r_enable && cnt == BURST_L - 4'd1))
      state_nxt = IDLE;
  end
  // state, beat count, round-robin memory and registered byte delivery
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      data_out <= '0;
      valid0   <= 1'b0;
      valid1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state == IDLE) ? 4'd0 : cnt + {3'd0, r_enable};
      if (state == IDLE && state_nxt != IDLE) last_gnt <= state_nxt == GRANT1;
      if (r_enable) data_out <= r_data;
      valid0   <= r_enable & gnt0;
      valid1   <= r_enable & gnt1;
    end
  end
endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// tb_rx_fifo_arbiter: randomized and directed checks against a queue-based reference model
module tb_rx_fifo_arbiter;
  localparam int BURST = 4;
  logic tb_clk = 1'b0;
  logic n_rst = 1'b0;
  logic empty, r_enable, req0, req1, rdy0, rdy1, gnt0, gnt1, valid0, valid1;
  logic [7:0] r_data, data_out;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] fifo[$];
  int owner = -1;
  int last = 1;
  int beats = 0;
  logic [7:0] exp_data = 8'h00;
  logic exp_v0 = 1'b0, exp_v1 = 1'b0;
  int v0_count = 0;

  rx_fifo_arbiter #(.BURST(BURST)) dut (
    .clk(tb_clk), .n_rst(n_rst), .empty(empty), .r_data(r_data), .r_enable(r_enable),
    .req0(req0), .req1(req1), .rdy0(rdy0), .rdy1(rdy1), .gnt0(gnt0), .gnt1(gnt1),
    .data_out(data_out), .valid0(valid0), .valid1(valid1)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    check("gnt0", {7'd0, gnt0}, {7'd0, owner == 0});
    check("gnt1", {7'd0, gnt1}, {7'd0, owner == 1});
    check("valid0", {7'd0, valid0}, {7'd0, exp_v0});
    check("valid1", {7'd0, valid1}, {7'd0, exp_v1});
    check("data_out", data_out, exp_data);
  endtask

  task automatic model_reset();
    owner = -1; last = 1; beats = 0;
    exp_data = 8'h00; exp_v0 = 1'b0; exp_v1 = 1'b0;
  endtask

  task automatic cycle(input logic r0, input logic r1, input logic y0, input logic y1);
    logic pop;
    logic want, can;
    @(negedge tb_clk);
    check_regs();
    req0 = r0; req1 = r1; rdy0 = y0; rdy1 = y1;
    empty = fifo.size() == 0;
    r_data = empty ? 8'($urandom) : fifo[0];
    #1;
    want = owner == 0 ? r0 : owner == 1 ? r1 : 1'b0;
    can  = owner == 0 ? y0 : owner == 1 ? y1 : 1'b0;
    pop = want && can && fifo.size() > 0 && beats < BURST;
    check("r_enable", {7'd0, r_enable}, {7'd0, pop});
    exp_v0 = pop && owner == 0;
    exp_v1 = pop && owner == 1;
    if (exp_v0) v0_count++;
    if (pop) exp_data = fifo.pop_front();
    if (owner < 0) begin
      if (r0 || r1) begin
        owner = (r0 && r1) ? (last == 1 ? 0 : 1) : (r0 ? 0 : 1);
        last = owner;
        beats = 0;
      end
    end else if (!want) owner = -1;
    else if (pop) begin
      beats++;
      if (beats == BURST) owner = -1;
    end
  endtask

  task automatic do_reset();
    @(negedge tb_clk);
    req0 = 0; req1 = 0; rdy0 = 0; rdy1 = 0;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_regs();
    check("rst_r_enable", {7'd0, r_enable}, 8'd0);
    @(negedge tb_clk);
    n_rst = 1'b1;
  endtask

  initial begin
    req0 = 0; req1 = 0; rdy0 = 0; rdy1 = 0; empty = 1; r_data = 0;
    #2;
    check_regs();
    check("rst_r_enable", {7'd0, r_enable}, 8'd0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    // two bytes, requester 0 alone, then holds with FIFO empty
    fifo.push_back(8'hA5); fifo.push_back(8'h3C);
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 0);
    check("q_drained", 8'(fifo.size()), 8'd0);
    check("last_byte", data_out, 8'h3C);
    check("gnt0_held", {7'd0, gnt0}, 8'd1);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    // full FIFO, both requesting from reset: round-robin bursts
    do_reset();
    for (int i = 0; i < 8; i++) fifo.push_back(8'(8'h10 + i));
    for (int i = 0; i < 14; i++) cycle(1, 1, 1, 1);
    check("full_drained", 8'(fifo.size()), 8'd0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    // requester 1 back-pressured mid-burst
    for (int i = 0; i < 4; i++) fifo.push_back(8'($urandom));
    cycle(0, 1, 0, 1); cycle(0, 1, 0, 1); cycle(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 0);
    // req0 dropped after two pops
    do_reset();
    fifo.delete();
    for (int i = 0; i < 8; i++) fifo.push_back(8'($urandom));
    v0_count = 0;
    cycle(1, 0, 1, 0); cycle(1, 0, 1, 0); cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
    check("drop_pops", 8'(v0_count), 8'd2);
    check("drop_left", 8'(fifo.size()), 8'd6);
    // reset mid-burst, then requester 1 alone
    cycle(1, 0, 1, 0); cycle(1, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1);
    check("after_rst_gnt1", {7'd0, gnt1}, 8'd1);
    // empty throughout
    do_reset();
    fifo.delete();
    v0_count = 0;
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
    check("empty_no_pop", 8'(v0_count), 8'd0);
    check("empty_gnt0", {7'd0, gnt0}, 8'd1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (fifo.size() < 12 && $urandom_range(0, 9) < 4) fifo.push_back(8'($urandom));
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    @(negedge tb_clk);
    check_regs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
